// File: rtl/vector_stream_serializer_if.sv
// Handshake bundle for vector_stream_serializer.
// master: the side that loads vectors and sinks elements; slave: the serializer.
interface vector_stream_serializer_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned LENW = $clog2(DEPTH) + 1;

   logic                   load;
   logic                   load_ready;
   logic [DEPTH*WIDTH-1:0] data_in;
   logic [LENW-1:0]        len;
   logic                   repeat_mode;
   logic                   flush;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       data_out;
   logic                   out_last;
   logic                   busy;

   modport master (
      output load, data_in, len, repeat_mode, flush, out_ready,
      input  load_ready, out_valid, data_out, out_last, busy
   );

   modport slave (
      input  load, data_in, len, repeat_mode, flush, out_ready,
      output load_ready, out_valid, data_out, out_last, busy
   );
endinterface

// File: rtl/vector_stream_serializer.sv
// Vector stream serializer: captures DEPTH elements of WIDTH bits in one load and
// streams them out one per valid/ready beat, with programmable length, repeat
// (wrap) mode, flush and a last-beat marker.
// Optional macro SERIALIZER_REVERSE_EN adds a 'reverse' input that streams the
// captured elements from index len-1 down to 0.
module vector_stream_serializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input logic clk,
   input logic reset,
`ifdef SERIALIZER_REVERSE_EN
   input logic reverse,
`endif
   vector_stream_serializer_if.slave bus
);
   localparam int unsigned IDXW = $clog2(DEPTH);
   localparam int unsigned LENW = $clog2(DEPTH) + 1;

   typedef enum logic [0:0] {StIdle, StStream} state_e;

   state_e                 state_q;
   logic [IDXW-1:0]        idx_q;
   logic [DEPTH*WIDTH-1:0] buf_q;
   logic [LENW-1:0]        len_q;
   logic                   mode_q;
`ifdef SERIALIZER_REVERSE_EN
   logic                   rev_q;
`else
   localparam logic        rev_q = 1'b0;
`endif

   logic [LENW-1:0] len_clamped;
   logic [LENW-1:0] len_m1;
   logic [IDXW-1:0] wrap_idx;
   logic [IDXW-1:0] step_idx;
   logic [IDXW-1:0] load_idx;
   logic            at_last;
   logic            streaming;
   logic            beat;

   // Index arithmetic shared by load, advance and wrap.
   always_comb begin
      len_clamped = (bus.len == '0 || bus.len > LENW'(DEPTH)) ? LENW'(DEPTH) : bus.len;
      len_m1      = len_q - LENW'(1);
      at_last     = rev_q ? (idx_q == '0) : (LENW'(idx_q) == len_m1);
      wrap_idx    = rev_q ? IDXW'(len_m1) : '0;
      step_idx    = rev_q ? (idx_q - IDXW'(1)) : (idx_q + IDXW'(1));
`ifdef SERIALIZER_REVERSE_EN
      load_idx    = reverse ? IDXW'(len_clamped - LENW'(1)) : '0;
`else
      load_idx    = '0;
`endif
      streaming   = (state_q == StStream);
      beat        = streaming && bus.out_ready;
   end

   // Output decode; data_out is driven from the registered index only.
   always_comb begin
      bus.busy       = streaming;
      bus.out_valid  = streaming;
      bus.load_ready = (state_q == StIdle) && !reset;
      bus.data_out   = streaming ? buf_q[idx_q*WIDTH +: WIDTH] : '0;
      bus.out_last   = streaming && at_last;
   end

   // Control FSM with operand capture; priority is reset > flush > beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         buf_q   <= '0;
         len_q   <= LENW'(DEPTH);
         mode_q  <= 1'b0;
`ifdef SERIALIZER_REVERSE_EN
         rev_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.load) begin
                  buf_q   <= bus.data_in;
                  len_q   <= len_clamped;
                  mode_q  <= bus.repeat_mode;
                  idx_q   <= load_idx;
`ifdef SERIALIZER_REVERSE_EN
                  rev_q   <= reverse;
`endif
                  state_q <= StStream;
               end
            end
            StStream: begin
               if (bus.flush) begin
                  // A beat in this cycle has already been delivered; just stop.
                  state_q <= StIdle;
                  idx_q   <= '0;
               end else if (beat) begin
                  if (!at_last) begin
                     idx_q <= step_idx;
                  end else if (mode_q) begin
                     idx_q <= wrap_idx;
                  end else begin
                     state_q <= StIdle;
                     idx_q   <= '0;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               idx_q   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_vector_stream_serializer.sv
// Self-checking bench for vector_stream_serializer: directed scenarios plus
// randomized traffic, checked each cycle against a sequence-level reference model.
module tb_vector_stream_serializer;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LENW  = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic reverse = 1'b0;

   always #5 clk = ~clk;

   vector_stream_serializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   vector_stream_serializer #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
`ifdef SERIALIZER_REVERSE_EN
      .reverse(reverse),
`endif
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the expected element sequence of the current burst and
   // how many beats of it have been delivered.
   bit               m_active = 1'b0;
   bit               m_rep    = 1'b0;
   int               m_len    = DEPTH;
   int               m_pos    = 0;
   logic [WIDTH-1:0] m_seq [DEPTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit rv;
      int idx;
      rv = 1'b0;
`ifdef SERIALIZER_REVERSE_EN
      rv = reverse;
`endif
      if (reset) begin
         m_active = 1'b0;
      end else if (m_active) begin
         if (bus.out_ready) begin
            m_pos++;
            if (m_pos == m_len) begin
               if (m_rep) m_pos = 0;
               else m_active = 1'b0;
            end
         end
         if (bus.flush) m_active = 1'b0;
      end else if (bus.load) begin
         m_len = (int'(bus.len) == 0 || int'(bus.len) > DEPTH) ? DEPTH : int'(bus.len);
         for (int k = 0; k < m_len; k++) begin
            idx = rv ? (m_len - 1 - k) : k;
            m_seq[k] = bus.data_in[idx*WIDTH +: WIDTH];
         end
         m_pos    = 0;
         m_rep    = bus.repeat_mode;
         m_active = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'(m_active));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(m_active));
      chk({tag, ".load_ready"}, 32'(bus.load_ready), 32'(!m_active && !reset));
      chk({tag, ".data"}, 32'(bus.data_out), m_active ? 32'(m_seq[m_pos]) : 32'h0);
      chk({tag, ".last"}, 32'(bus.out_last), 32'(m_active && (m_pos == m_len - 1)));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   task automatic idle_inputs();
      bus.load        = 1'b0;
      bus.flush       = 1'b0;
      bus.out_ready   = 1'b1;
      bus.len         = '0;
      bus.repeat_mode = 1'b0;
      bus.data_in     = 32'h44332211;
      reverse         = 1'b0;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      step("rst");
      step("rst");
      chk("rst.load_ready", 32'(bus.load_ready), 32'h0);
      chk("rst.data", 32'(bus.data_out), 32'h0);
      reset = 1'b0;
      step("idle");

      // 1: full-length burst with sink always ready.
      bus.load = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step("t1");
         bus.load = 1'b0;
         chk("t1.data_const", 32'(bus.data_out), 32'h11 * (i + 1));
         chk("t1.last_const", 32'(bus.out_last), 32'(i == 3));
      end
      step("t1.end");
      chk("t1.ready_back", 32'(bus.load_ready), 32'h1);
      step("t1.gap");

      // 2: backpressure holds the element.
      bus.load = 1'b1;
      step("t2");
      bus.load = 1'b0;
      step("t2");
      bus.out_ready = 1'b0;
      step("t2");
      step("t2");
      chk("t2.hold_const", 32'(bus.data_out), 32'h22);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step("t2");

      // 3: repeat mode, len=2, then flush.
      bus.len = 3'd2;
      bus.repeat_mode = 1'b1;
      bus.load = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step("t3");
         bus.load = 1'b0;
         chk("t3.data_const", 32'(bus.data_out), (i % 2 == 0) ? 32'h11 : 32'h22);
      end
      bus.flush = 1'b1;
      step("t3.flush");
      bus.flush = 1'b0;
      chk("t3.flush_valid", 32'(bus.out_valid), 32'h0);
      idle_inputs();
      step("t3.idle");

      // 4: oversize length clamps; a load mid-stream is ignored.
      bus.len = 3'd7;
      bus.load = 1'b1;
      step("t4");
      bus.load = 1'b0;
      step("t4");
      bus.load = 1'b1;
      bus.data_in = 32'hDDCCBBAA;
      step("t4");
      bus.load = 1'b0;
      step("t4");
      chk("t4.last_data", 32'(bus.data_out), 32'h44);
      chk("t4.last_flag", 32'(bus.out_last), 32'h1);
      idle_inputs();
      step("t4.end");

      // 5: reset mid-stream, then a fresh len=3 burst.
      bus.load = 1'b1;
      step("t5");
      bus.load = 1'b0;
      step("t5");
      step("t5");
      reset = 1'b1;
      step("t5.rst");
      chk("t5.rst_valid", 32'(bus.out_valid), 32'h0);
      chk("t5.rst_busy", 32'(bus.busy), 32'h0);
      reset = 1'b0;
      step("t5.idle");
      bus.len = 3'd3;
      bus.load = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step("t5.b");
         bus.load = 1'b0;
         chk("t5.data_const", 32'(bus.data_out), 32'h11 * (i + 1));
      end
      idle_inputs();
      step("t5.end");

`ifdef SERIALIZER_REVERSE_EN
      // 6: reverse order over len=3.
      bus.len = 3'd3;
      reverse = 1'b1;
      bus.load = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step("t6");
         bus.load = 1'b0;
         chk("t6.data_const", 32'(bus.data_out), 32'h11 * (3 - i));
         chk("t6.last_const", 32'(bus.out_last), 32'(i == 2));
      end
      idle_inputs();
      step("t6.end");
`endif

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         reset           = ($urandom_range(199) == 0);
         bus.load        = ($urandom_range(2) == 0);
         bus.flush       = ($urandom_range(15) == 0);
         bus.out_ready   = ($urandom_range(3) != 0);
         bus.len         = LENW'($urandom_range(7));
         bus.repeat_mode = ($urandom_range(3) == 0);
         bus.data_in     = (DEPTH*WIDTH)'($urandom());
         reverse         = 1'($urandom_range(1));
         step("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
